// File: rtl/console_pkg.sv
// Shared types and control codes for the text console writer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package console_pkg;

  localparam logic [7:0] CC_BS  = 8'h08;
  localparam logic [7:0] CC_TAB = 8'h09;
  localparam logic [7:0] CC_LF  = 8'h0A;
  localparam logic [7:0] CC_FF  = 8'h0C;
  localparam logic [7:0] CC_CR  = 8'h0D;

  typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_LINE} console_state_t;

  typedef logic [6:0] col_t;
  typedef logic [4:0] row_t;

  // Tile RAM address: row in the upper bits, column in the lower bits.
  function automatic logic [11:0] tile_addr(input row_t r, input col_t c);
    return {r, c};
  endfunction

endpackage

// File: rtl/text_console_writer.sv
// Byte stream to tile VRAM writer with cursor, line clear and full-screen clear.
// Latency: a byte accepted in cycle N drives its write on vram_* in cycle N+1.
// Backpressure: char_ready is low while a clear runs; optional TAB handling under TEXT_TAB_EN.
module text_console_writer
  import console_pkg::*;
#(
  parameter int         COLS      = 80,
  parameter int         ROWS      = 30,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic        clk_pix,
  input  logic        rst_n,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  input  logic        clear_req,
  output logic        vram_we,
  output logic [11:0] vram_waddr,
  output logic [7:0]  vram_din,
  output logic [6:0]  cur_col,
  output logic [4:0]  cur_row,
  output logic        busy
);

  localparam col_t COL_LAST = col_t'(COLS - 1);
  localparam row_t ROW_LAST = row_t'(ROWS - 1);

  console_state_t state, state_nxt;
  logic [11:0]    cnt, cnt_nxt;
  col_t           col_nxt;
  row_t           row_nxt, row_adv;
  logic           we_nxt;
  logic [11:0]    waddr_nxt;
  logic [7:0]     din_nxt;
  logic           accept;
  logic           do_newline;
  logic           do_clear;

`ifdef TEXT_TAB_EN
  localparam logic [7:0] COLS_W = 8'(COLS);
  logic [7:0] tab_col;
  // Next multiple of 8 strictly above the current column.
  assign tab_col = {1'b0, cur_col[6:3], 3'b000} + 8'd8;
`endif

  // char_ready mirrors state == IDLE, so it doubles as the accept qualifier.
  assign accept  = char_valid && char_ready;
  assign row_adv = (cur_row >= ROW_LAST) ? '0 : cur_row + 5'd1;

  // Next-state, cursor and write-port decode.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    col_nxt    = cur_col;
    row_nxt    = cur_row;
    we_nxt     = 1'b0;
    waddr_nxt  = vram_waddr;
    din_nxt    = vram_din;
    do_newline = 1'b0;
    do_clear   = clear_req;

    case (state)
      CLR_ALL: begin
        we_nxt    = 1'b1;
        waddr_nxt = cnt;
        din_nxt   = FILL_CHAR;
        if (cnt == 12'hFFF) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          col_nxt   = '0;
          row_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 12'd1;
        end
      end

      CLR_LINE: begin
        we_nxt    = 1'b1;
        waddr_nxt = tile_addr(cur_row, cnt[6:0]);
        din_nxt   = FILL_CHAR;
        if (cnt[6:0] >= COL_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 12'd1;
        end
      end

      default: begin
        if (accept) begin
          case (char_data)
            CC_CR: col_nxt = '0;
            CC_LF: do_newline = 1'b1;
            CC_BS: begin
              if (cur_col != '0) begin
                col_nxt   = cur_col - 7'd1;
                we_nxt    = 1'b1;
                waddr_nxt = tile_addr(cur_row, cur_col - 7'd1);
                din_nxt   = FILL_CHAR;
              end
            end
            CC_FF: do_clear = 1'b1;
`ifdef TEXT_TAB_EN
            CC_TAB: begin
              if (tab_col >= COLS_W) do_newline = 1'b1;
              else                   col_nxt    = tab_col[6:0];
            end
`endif
            default: begin
              we_nxt    = 1'b1;
              waddr_nxt = tile_addr(cur_row, cur_col);
              din_nxt   = char_data;
              if (cur_col >= COL_LAST) do_newline = 1'b1;
              else                     col_nxt    = cur_col + 7'd1;
            end
          endcase
        end
      end
    endcase

    // The next line of the circular buffer is blanked before it is used.
    if (do_newline) begin
      col_nxt   = '0;
      row_nxt   = row_adv;
      state_nxt = CLR_LINE;
      cnt_nxt   = '0;
    end

    // Clear wins over everything, including a byte accepted this cycle.
    if (do_clear) begin
      state_nxt = CLR_ALL;
      cnt_nxt   = '0;
      col_nxt   = '0;
      row_nxt   = '0;
      we_nxt    = 1'b0;
    end
  end

  // Register state and every output; status flags track the next state.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLR_ALL;
      cnt        <= '0;
      cur_col    <= '0;
      cur_row    <= '0;
      vram_we    <= 1'b0;
      vram_waddr <= '0;
      vram_din   <= '0;
      char_ready <= 1'b0;
      busy       <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cur_col    <= col_nxt;
      cur_row    <= row_nxt;
      vram_we    <= we_nxt;
      vram_waddr <= waddr_nxt;
      vram_din   <= din_nxt;
      char_ready <= (state_nxt == IDLE);
      busy       <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: reset clear, glyphs, wrap, LF, CR, BS, clears, TAB.
// Inputs change and outputs are sampled on the falling edge of clk_pix.
// VRAM writes are logged after each rising edge into a queue for content checks.
module tb_text_console_writer;

  logic        clk_pix = 1'b0;
  logic        rst_n = 1'b1;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        clear_req = 1'b0;
  logic        char_ready;
  logic        vram_we;
  logic [11:0] vram_waddr;
  logic [7:0]  vram_din;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
  logic        busy;

  int tests = 0;
  int fails = 0;
  logic [19:0] wq[$];

  text_console_writer #(.COLS(80), .ROWS(30), .FILL_CHAR(8'h20)) dut (
    .clk_pix(clk_pix), .rst_n(rst_n),
    .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
    .clear_req(clear_req),
    .vram_we(vram_we), .vram_waddr(vram_waddr), .vram_din(vram_din),
    .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
  );

  always #5 clk_pix = ~clk_pix;

  // Write log, captured just after the edge that produced it.
  always @(posedge clk_pix) begin
    #1;
    if (rst_n && vram_we) wq.push_back({vram_waddr, vram_din});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare count log entries from idx against consecutive addresses with one data value.
  task automatic check_run(input string tag, input int idx, input int base, input int count,
                           input logic [7:0] data);
    int bad = 0;
    for (int i = 0; i < count; i++) begin
      if (idx + i >= wq.size()) bad++;
      else if (wq[idx + i] !== {12'(base + i), data}) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!char_ready && n < 6000) begin
      @(negedge clk_pix);
      n++;
    end
  endtask

  // Offer one byte; returns on the falling edge after the handshake.
  task automatic send(input logic [7:0] b);
    int n;
    wait_ready(n);
    check("send_ready", char_ready, 1);
    char_valid = 1'b1;
    char_data  = b;
    @(negedge clk_pix);
    char_valid = 1'b0;
  endtask

  initial begin
    int n;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk_pix);
    check("rst_busy", busy, 1);
    check("rst_ready", char_ready, 0);
    check("rst_we", vram_we, 0);
    check("rst_waddr", vram_waddr, 0);
    check("rst_din", vram_din, 0);
    check("rst_cursor", {cur_row, cur_col}, 0);

    // Automatic full clear after reset release.
    rst_n = 1'b1;
    wq.delete();
    n = 0;
    do begin
      @(negedge clk_pix);
      n++;
    end while (busy && n < 6000);
    check("clrall_cycles", n, 4096);
    check("clrall_count", wq.size(), 4096);
    check_run("clrall_data", 0, 0, 4096, 8'h20);
    check("clrall_ready", char_ready, 1);
    check("clrall_cursor", {cur_row, cur_col}, 0);
    @(negedge clk_pix);
    check("clrall_we_off", vram_we, 0);

    // Two glyphs, each written one cycle after its handshake.
    send(8'h41);
    check("A_we", vram_we, 1);
    check("A_addr", vram_waddr, 12'h000);
    check("A_din", vram_din, 8'h41);
    send(8'h42);
    check("B_addr", vram_waddr, 12'h001);
    check("B_din", vram_din, 8'h42);
    check("B_col", cur_col, 2);
    @(negedge clk_pix);
    check("B_we_pulse", vram_we, 0);

    // CR: home column, no write.
    send(8'h0D);
    check("cr_we", vram_we, 0);
    check("cr_cursor", {cur_row, cur_col}, 0);

    // Full row of glyphs wraps and clears row 1.
    wq.delete();
    repeat (80) send(8'h58);
    check("wrap_addr", vram_waddr, 12'h04F);
    check("wrap_din", vram_din, 8'h58);
    check("wrap_cursor", {cur_row, cur_col}, 12'h080);
    check("wrap_ready_low", char_ready, 0);
    wait_ready(n);
    check("wrap_clr_cycles", n, 80);
    check("wrap_count", wq.size(), 160);
    check_run("wrap_glyphs", 0, 0, 80, 8'h58);
    check_run("wrap_clrline", 80, 12'h080, 80, 8'h20);

    // Walk down to row 29, column 5, then LF wraps to row 0.
    repeat (28) send(8'h0A);
    repeat (5) send(8'h61);
    check("r29_cursor", {cur_row, cur_col}, (29 << 7) | 5);
    wq.delete();
    send(8'h0A);
    check("lfwrap_cursor", {cur_row, cur_col}, 0);
    check("lfwrap_ready_low", char_ready, 0);
    wait_ready(n);
    check("lfwrap_cycles", n, 80);
    check("lfwrap_count", wq.size(), 80);
    check_run("lfwrap_clr", 0, 0, 80, 8'h20);
    repeat (5) send(8'h63);
    send(8'h0D);
    check("cr5_we", vram_we, 0);
    check("cr5_col", cur_col, 0);

    // Backspace in the middle of a line and at column 0.
    repeat (3) send(8'h64);
    send(8'h08);
    check("bs_we", vram_we, 1);
    check("bs_addr", vram_waddr, 12'h002);
    check("bs_din", vram_din, 8'h20);
    check("bs_col", cur_col, 2);
    send(8'h08);
    send(8'h08);
    check("bs_col0", cur_col, 0);
    send(8'h08);
    check("bs0_we", vram_we, 0);
    check("bs0_cursor", {cur_row, cur_col}, 0);

    // clear_req during CLR_LINE together with an offered byte.
    send(8'h0A);
    repeat (10) @(negedge clk_pix);
    check("cl_busy", busy, 1);
    clear_req  = 1'b1;
    char_valid = 1'b1;
    char_data  = 8'h5A;
    @(negedge clk_pix);
    clear_req  = 1'b0;
    char_valid = 1'b0;
    wq.delete();
    check("cl_cursor", {cur_row, cur_col}, 0);
    check("cl_busy_after", busy, 1);
    @(negedge clk_pix);
    check("cl_restart_we", vram_we, 1);
    check("cl_restart_addr", vram_waddr, 12'h000);
    wait_ready(n);
    check("cl_cycles", n, 4095);
    check("cl_count", wq.size(), 4096);
    check_run("cl_data", 0, 0, 4096, 8'h20);

    // clear_req in IDLE beats a byte accepted in the same cycle.
    send(8'h41);
    clear_req  = 1'b1;
    char_valid = 1'b1;
    char_data  = 8'h51;
    @(negedge clk_pix);
    clear_req  = 1'b0;
    char_valid = 1'b0;
    wq.delete();
    check("ci_busy", busy, 1);
    check("ci_cursor", {cur_row, cur_col}, 0);
    wait_ready(n);
    check("ci_cycles", n, 4096);
    check("ci_count", wq.size(), 4096);
    check_run("ci_data", 0, 0, 4096, 8'h20);

    // Form feed acts as a clear.
    send(8'h41);
    send(8'h0C);
    check("ff_busy", busy, 1);
    check("ff_ready", char_ready, 0);
    check("ff_cursor", {cur_row, cur_col}, 0);
    wait_ready(n);
    check("ff_cycles", n, 4096);

`ifdef TEXT_TAB_EN
    repeat (3) send(8'h65);
    send(8'h09);
    check("tab_we", vram_we, 0);
    check("tab_col", cur_col, 8);
    repeat (69) send(8'h66);
    check("tab77_col", cur_col, 77);
    send(8'h09);
    check("tabwrap_cursor", {cur_row, cur_col}, 12'h080);
    check("tabwrap_ready", char_ready, 0);
    wait_ready(n);
    check("tabwrap_cycles", n, 80);
`else
    send(8'h09);
    check("tab_glyph_we", vram_we, 1);
    check("tab_glyph_addr", vram_waddr, 12'h000);
    check("tab_glyph_din", vram_din, 8'h09);
    check("tab_glyph_col", cur_col, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
